// File: rtl/collision_scanner_if.sv
// Bus bundle between the game data RAM side and the collision scanner.
// Carries the scan request, the packed position words and the published hit masks.
interface collision_scanner_if;
  logic         start;
  logic [319:0] spriteX;
  logic [319:0] spriteY;
  logic [159:0] bulletX;
  logic [159:0] bulletY;
  logic [31:0]  playerX;
  logic [31:0]  playerY;
  logic         busy;
  logic         done;
  logic [9:0]   spriteHit;
  logic [4:0]   bulletHit;
  logic         playerHit;

  modport master (
    output start, spriteX, spriteY, bulletX, bulletY, playerX, playerY,
    input  busy, done, spriteHit, bulletHit, playerHit
  );

  modport slave (
    input  start, spriteX, spriteY, bulletX, bulletY, playerX, playerY,
    output busy, done, spriteHit, bulletHit, playerHit
  );
endinterface

// File: rtl/collision_scanner.sv
// Per-frame collision checker: snapshots all positions on start, then tests one
// bullet-sprite or sprite-player pair per cycle and publishes the hit masks.
module collision_scanner #(
  parameter int unsigned SPRITE_W   = 32,
  parameter int unsigned SPRITE_H   = 32,
  parameter int unsigned BULLET_W   = 4,
  parameter int unsigned BULLET_H   = 8,
  parameter int unsigned PLAYER_W   = 32,
  parameter int unsigned PLAYER_H   = 16,
  parameter int unsigned INACTIVE_X = 640
) (
  input logic                clk,
  input logic                reset,
  collision_scanner_if.slave scan_io
);

  localparam logic [32:0] SprW  = 33'(SPRITE_W);
  localparam logic [32:0] SprH  = 33'(SPRITE_H);
  localparam logic [32:0] BulW  = 33'(BULLET_W);
  localparam logic [32:0] BulH  = 33'(BULLET_H);
  localparam logic [32:0] PlyW  = 33'(PLAYER_W);
  localparam logic [32:0] PlyH  = 33'(PLAYER_H);
  localparam logic [31:0] InactX = 32'(INACTIVE_X);

  typedef enum logic [1:0] {StIdle, StBullet, StPlayer, StDone} state_e;

  state_e state_q, state_d;

  logic [319:0] spr_x_q, spr_x_d, spr_y_q, spr_y_d;
  logic [159:0] bul_x_q, bul_x_d, bul_y_q, bul_y_d;
  logic [31:0]  ply_x_q, ply_x_d, ply_y_q, ply_y_d;
  logic [3:0]   s_q, s_d;
  logic [2:0]   b_q, b_d;
  logic [9:0]   spr_acc_q, spr_acc_d;
  logic [4:0]   bul_acc_q, bul_acc_d;
  logic         ply_acc_q, ply_acc_d;
  logic [9:0]   spr_hit_q, spr_hit_d;
  logic [4:0]   bul_hit_q, bul_hit_d;
  logic         ply_hit_q, ply_hit_d;
  logic         done_q, done_d;
  logic         busy;

  logic [31:0] cur_sx, cur_sy, cur_bx, cur_by;
  logic        bul_pair_hit, ply_pair_hit;

  // Sums widened to 33 bits so objects near the top of the range cannot wrap.
  function automatic logic boxes_overlap(
    input logic [31:0] ax, input logic [31:0] ay, input logic [32:0] aw, input logic [32:0] ah,
    input logic [31:0] bx, input logic [31:0] by, input logic [32:0] bw, input logic [32:0] bh
  );
    return ({1'b0, ax} < ({1'b0, bx} + bw)) && ({1'b0, bx} < ({1'b0, ax} + aw)) &&
           ({1'b0, ay} < ({1'b0, by} + bh)) && ({1'b0, by} < ({1'b0, ay} + ah));
  endfunction

  always_comb begin
    cur_sx = spr_x_q[{s_q, 5'b0} +: 32];
    cur_sy = spr_y_q[{s_q, 5'b0} +: 32];
    cur_bx = bul_x_q[{b_q, 5'b0} +: 32];
    cur_by = bul_y_q[{b_q, 5'b0} +: 32];
    bul_pair_hit = (cur_bx < InactX) && (cur_sx < InactX) &&
                   boxes_overlap(cur_bx, cur_by, BulW, BulH, cur_sx, cur_sy, SprW, SprH);
    ply_pair_hit = (ply_x_q < InactX) && (cur_sx < InactX) &&
                   boxes_overlap(cur_sx, cur_sy, SprW, SprH, ply_x_q, ply_y_q, PlyW, PlyH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (scan_io.start) state_d = StBullet;
      StBullet: if (b_q == 3'd4 && s_q == 4'd9) state_d = StPlayer;
      StPlayer: if (s_q == 4'd9) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  always_comb begin
    spr_x_d   = spr_x_q;
    spr_y_d   = spr_y_q;
    bul_x_d   = bul_x_q;
    bul_y_d   = bul_y_q;
    ply_x_d   = ply_x_q;
    ply_y_d   = ply_y_q;
    s_d       = s_q;
    b_d       = b_q;
    spr_acc_d = spr_acc_q;
    bul_acc_d = bul_acc_q;
    ply_acc_d = ply_acc_q;
    spr_hit_d = spr_hit_q;
    bul_hit_d = bul_hit_q;
    ply_hit_d = ply_hit_q;
    done_d    = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (scan_io.start) begin
          spr_x_d   = scan_io.spriteX;
          spr_y_d   = scan_io.spriteY;
          bul_x_d   = scan_io.bulletX;
          bul_y_d   = scan_io.bulletY;
          ply_x_d   = scan_io.playerX;
          ply_y_d   = scan_io.playerY;
          s_d       = '0;
          b_d       = '0;
          spr_acc_d = '0;
          bul_acc_d = '0;
          ply_acc_d = 1'b0;
        end
      end
      StBullet: begin
        if (bul_pair_hit) begin
          spr_acc_d[s_q] = 1'b1;
          bul_acc_d[b_q] = 1'b1;
        end
        if (s_q == 4'd9) begin
          s_d = '0;
          b_d = (b_q == 3'd4) ? 3'd0 : b_q + 3'd1;
        end else begin
          s_d = s_q + 4'd1;
        end
      end
      StPlayer: begin
        if (ply_pair_hit) begin
          spr_acc_d[s_q] = 1'b1;
          ply_acc_d      = 1'b1;
        end
        s_d = (s_q == 4'd9) ? 4'd0 : s_q + 4'd1;
      end
      StDone: begin
        spr_hit_d = spr_acc_q;
        bul_hit_d = bul_acc_q;
        ply_hit_d = ply_acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spr_x_q   <= '0;
      spr_y_q   <= '0;
      bul_x_q   <= '0;
      bul_y_q   <= '0;
      ply_x_q   <= '0;
      ply_y_q   <= '0;
      s_q       <= '0;
      b_q       <= '0;
      spr_acc_q <= '0;
      bul_acc_q <= '0;
      ply_acc_q <= 1'b0;
      spr_hit_q <= '0;
      bul_hit_q <= '0;
      ply_hit_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      spr_x_q   <= spr_x_d;
      spr_y_q   <= spr_y_d;
      bul_x_q   <= bul_x_d;
      bul_y_q   <= bul_y_d;
      ply_x_q   <= ply_x_d;
      ply_y_q   <= ply_y_d;
      s_q       <= s_d;
      b_q       <= b_d;
      spr_acc_q <= spr_acc_d;
      bul_acc_q <= bul_acc_d;
      ply_acc_q <= ply_acc_d;
      spr_hit_q <= spr_hit_d;
      bul_hit_q <= bul_hit_d;
      ply_hit_q <= ply_hit_d;
      done_q    <= done_d;
    end
  end

  assign scan_io.busy      = busy;
  assign scan_io.done      = done_q;
  assign scan_io.spriteHit = spr_hit_q;
  assign scan_io.bulletHit = bul_hit_q;
  assign scan_io.playerHit = ply_hit_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: directed scenarios plus random scenes, each scan
// compared against a pairwise box-overlap model of the whole frame.
module tb_collision_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  collision_scanner_if bus ();

  collision_scanner dut (
    .clk    (clk),
    .reset  (reset),
    .scan_io(bus)
  );

  int unsigned sx[10], sy[10], bx[5], by[5], px, py;
  int          vectors = 0;
  int          fails   = 0;
  logic [9:0]  exp_spr;
  logic [4:0]  exp_bul;
  logic        exp_ply;

  function automatic bit ovl(longint ax, longint ay, longint aw, longint ah,
                             longint cx, longint cy, longint cw, longint ch);
    return (ax < cx + cw) && (cx < ax + aw) && (ay < cy + ch) && (cy < ay + ah);
  endfunction

  function automatic bit act(int unsigned x);
    return x < 640;
  endfunction

  task automatic model();
    exp_spr = '0;
    exp_bul = '0;
    exp_ply = 1'b0;
    for (int b = 0; b < 5; b++)
      for (int s = 0; s < 10; s++)
        if (act(bx[b]) && act(sx[s]) && ovl(bx[b], by[b], 4, 8, sx[s], sy[s], 32, 32)) begin
          exp_spr[s] = 1'b1;
          exp_bul[b] = 1'b1;
        end
    for (int s = 0; s < 10; s++)
      if (act(px) && act(sx[s]) && ovl(sx[s], sy[s], 32, 32, px, py, 32, 16)) begin
        exp_spr[s] = 1'b1;
        exp_ply    = 1'b1;
      end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 10; i++) begin
      bus.spriteX[32*i +: 32] = sx[i];
      bus.spriteY[32*i +: 32] = sy[i];
    end
    for (int i = 0; i < 5; i++) begin
      bus.bulletX[32*i +: 32] = bx[i];
      bus.bulletY[32*i +: 32] = by[i];
    end
    bus.playerX = px;
    bus.playerY = py;
  endtask

  task automatic park();
    for (int i = 0; i < 10; i++) begin sx[i] = 640; sy[i] = 0; end
    for (int i = 0; i < 5; i++) begin bx[i] = 640; by[i] = 0; end
    px = 640;
    py = 0;
  endtask

  task automatic check_masks(input string tag);
    check({tag, "_spr"}, 32'(bus.spriteHit), 32'(exp_spr));
    check({tag, "_bul"}, 32'(bus.bulletHit), 32'(exp_bul));
    check({tag, "_ply"}, 32'(bus.playerHit), 32'(exp_ply));
  endtask

  // Pulse start with the current scene, wait for done, check latency, busy and masks.
  task automatic run_scan(input string tag);
    int   lat;
    logic busy60;
    model();
    drive();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    lat    = 0;
    busy60 = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (i == 60) busy60 = bus.busy;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd61);
    check({tag, "_busy60"}, 32'(busy60), 32'd1);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check_masks(tag);
    @(posedge clk);
    #1 check({tag, "_done_width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int ndone;
    int lat;

    reset     = 1'b1;
    bus.start = 1'b0;
    park();
    drive();
    repeat (2) @(posedge clk);
    #1;
    exp_spr = '0; exp_bul = '0; exp_ply = 1'b0;
    check_masks("reset");
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single hit
    park();
    sx[0] = 100; sy[0] = 50; bx[0] = 110; by[0] = 60;
    run_scan("single");
    check("single_direct", 32'(bus.spriteHit), 32'h1);

    // Touching edge, then one-pixel overlap
    park();
    sx[0] = 100; sy[0] = 50; bx[0] = 132; by[0] = 60;
    run_scan("touch");
    bx[0] = 131;
    run_scan("overlap1");

    // Inactive objects and a bullet near the top of the coordinate range
    park();
    sx[3] = 640; sy[3] = 50; bx[2] = 645; by[2] = 55;
    sx[0] = 0; sy[0] = 10; bx[4] = 32'hFFFF_FFF0; by[4] = 10;
    run_scan("inactive");

    // Player collision; one bullet across several sprites as well
    park();
    px = 100; py = 440; sx[7] = 110; sy[7] = 420;
    run_scan("player");
    park();
    sx[1] = 200; sy[1] = 100; sx[2] = 230; sy[2] = 100; bx[3] = 229; by[3] = 110;
    px = 220; py = 125;
    run_scan("multi");

    // Snapshot: scene changes mid-scan, extra start pulses mid-scan and in DONE
    park();
    sx[0] = 100; sy[0] = 50; bx[0] = 200; by[0] = 60;
    model();
    drive();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0;
    lat   = 0;
    for (int i = 1; i <= 75; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (lat == 0) lat = i;
      end
      if (i == 5) begin sx[0] = 190; drive(); end
      if (i == 9) bus.start = 1'b1;
      if (i == 10) bus.start = 1'b0;
      if (i == 60) bus.start = 1'b1;
      if (i == 61) begin
        bus.start = 1'b0;
        check("start_in_done_ignored", 32'(bus.busy), 32'd0);
      end
    end
    check("snap_done_count", 32'(ndone), 32'd1);
    check("snap_latency", 32'(lat), 32'd61);
    check_masks("snap");

    // Reset mid-scan after a scan that left nonzero outputs
    park();
    px = 100; py = 440; sx[7] = 110; sy[7] = 420;
    run_scan("pre_reset");
    drive();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    exp_spr = '0; exp_bul = '0; exp_ply = 1'b0;
    check_masks("async_reset");
    check("async_reset_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("reset_no_done", 32'(ndone), 32'd0);
    check("reset_idle", 32'(bus.busy), 32'd0);
    run_scan("post_reset");

    // Random scenes
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 10; i++) begin
        sx[i] = ($urandom_range(0, 5) == 0) ? 640 + $urandom_range(0, 100) : $urandom_range(0, 300);
        sy[i] = $urandom_range(0, 200);
      end
      for (int i = 0; i < 5; i++) begin
        bx[i] = ($urandom_range(0, 5) == 0) ? 640 + $urandom_range(0, 100) : $urandom_range(0, 300);
        by[i] = $urandom_range(0, 200);
      end
      px = ($urandom_range(0, 7) == 0) ? 700 : $urandom_range(0, 300);
      py = $urandom_range(0, 200);
      run_scan("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
